writeback_unit: RTL and testbench

Final pipeline stage of the MIPS core, feeding the register file's single write port (RDaddr/RDdata/RegWrite). It accepts one retiring instruction per cycle from EX/MEM and performs ALU results directly. For loads, it runs a request/acknowledge transaction to data memory, then aligns and sign- or zero-extends the returned data before writing. It stalls upstream while a load is outstanding and never issues a write to $zero.

---
 rtl/writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_writeback_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Final MIPS pipeline stage: retires ALU results and runs load request/ack transactions into the register-file write port.
// Latency: ALU op writes 1 cycle after accept; a load writes 1 cycle after ack. Upstream stalls while a load is outstanding.
module writeback_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [31:0] ALUres_i,
    output logic        stall_o,
    output logic        req_o,
    output logic [31:0] addr_o,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic        err_o,
    output logic [31:0] retired_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        stall_q, stall_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        ld_we_q, ld_we_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_uns_q, ld_uns_d;
    logic        wr_q, wr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] retired_q, retired_d;
    logic        misaligned;

    // Pick the addressed byte/half out of the little-endian word, then extend.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (sz)
            2'd0:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign misaligned = ((size_i == 2'd1) && ALUres_i[0]) ||
                        (size_i[1] && (ALUres_i[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ld_we_d   = ld_we_q;
        ld_rd_d   = ld_rd_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        wr_d      = 1'b0;
        rd_d      = rd_q;
        data_d    = data_q;
        err_d     = 1'b0;
        retired_d = retired_q + {31'b0, wr_q};

        case (state_q)
            WAIT_MEM: begin
                if (ack_i) begin
                    req_d   = 1'b0;
                    state_d = WRITE;
                    wr_d    = ld_we_q && (ld_rd_q != 5'd0);
                    if (wr_d) begin
                        rd_d   = ld_rd_q;
                        data_d = extract(rdata_i, addr_q[1:0], ld_size_q, ld_uns_q);
                    end
                end
            end
            default: begin
                // IDLE and WRITE both accept a new instruction.
                state_d = IDLE;
                if (valid_i) begin
                    if (MemRead_i) begin
                        if (misaligned) begin
                            err_d = 1'b1;
                        end else begin
                            ld_we_d   = RegWrite_i;
                            ld_rd_d   = RDaddr_i;
                            ld_size_d = size_i;
                            ld_uns_d  = unsigned_i;
                            addr_d    = ALUres_i;
                            req_d     = 1'b1;
                            state_d   = WAIT_MEM;
                        end
                    end else begin
                        wr_d = RegWrite_i && (RDaddr_i != 5'd0);
                        if (wr_d) begin
                            rd_d   = RDaddr_i;
                            data_d = ALUres_i;
                        end
                    end
                end
            end
        endcase

        stall_d = (state_d == WAIT_MEM);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            stall_q   <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= 32'b0;
            ld_we_q   <= 1'b0;
            ld_rd_q   <= 5'b0;
            ld_size_q <= 2'b0;
            ld_uns_q  <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 5'b0;
            data_q    <= 32'b0;
            err_q     <= 1'b0;
            retired_q <= 32'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ld_we_q   <= ld_we_d;
            ld_rd_q   <= ld_rd_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign stall_o    = stall_q;
    assign req_o      = req_q;
    assign addr_o     = addr_q;
    assign RegWrite_o = wr_q;
    assign RDaddr_o   = rd_q;
    assign RDdata_o   = data_q;
    assign err_o      = err_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus randomized instruction stream scored against a transaction-level model.
module tb_writeback_unit;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i, RegWrite_i, MemRead_i, unsigned_i, ack_i;
    logic [1:0]  size_i;
    logic [4:0]  RDaddr_i;
    logic [31:0] ALUres_i, rdata_i;
    logic        stall_o, req_o, RegWrite_o, err_o;
    logic [31:0] addr_o, RDdata_o, retired_o;
    logic [4:0]  RDaddr_o;

    writeback_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .size_i(size_i), .unsigned_i(unsigned_i), .RDaddr_i(RDaddr_i),
        .ALUres_i(ALUres_i), .stall_o(stall_o), .req_o(req_o), .addr_o(addr_o), .ack_i(ack_i),
        .rdata_i(rdata_i), .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
        .err_o(err_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    int writes_exp = 0;
    logic [36:0] exp_q[$];   // {rd, data} of expected register writes, in order

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> ((addr % 4) * 8)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (word >> (((addr % 4) / 2) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] sz);
        if (sz == 2'd1) return (addr % 2) != 0;
        if (sz >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic void expect_write(input logic [4:0] rd, input logic [31:0] d, input bit we);
        if (we && rd != 5'd0) begin
            exp_q.push_back({rd, d});
            writes_exp++;
        end
    endfunction

    // Scoreboard: every write pulse must match the next expected write.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (RegWrite_o) begin
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(RDaddr_o), 32'(e[36:32]));
                    chk("wr_data", RDdata_o, e[31:0]);
                end
            end
            if (err_o) err_seen++;
        end
    end

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d, input bit we);
        valid_i    = 1'b1;
        MemRead_i  = 1'b0;
        RegWrite_i = we;
        RDaddr_i   = rd;
        ALUres_i   = d;
        size_i     = 2'($urandom);
        ack_i      = ($urandom % 4) == 0;   // stray acks must be ignored
        rdata_i    = $urandom;
        chk("alu_no_stall", 32'(stall_o), 0);
        expect_write(rd, d, we);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        ack_i   = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] sz,
                        input bit uns, input bit we, input int waits, input logic [31:0] word,
                        input bit hold, input logic [4:0] hrd, input logic [31:0] hdata);
        valid_i    = 1'b1;
        MemRead_i  = 1'b1;
        RegWrite_i = we;
        RDaddr_i   = rd;
        ALUres_i   = addr;
        size_i     = sz;
        unsigned_i = uns;
        @(posedge clk_i);
        #1;
        if (hold) begin
            MemRead_i  = 1'b0;
            RegWrite_i = 1'b1;
            RDaddr_i   = hrd;
            ALUres_i   = hdata;
        end else begin
            valid_i = 1'b0;
        end
        if (model_misaligned(addr, sz)) begin
            err_exp++;
            if (hold) expect_write(hrd, hdata, 1'b1);
            @(negedge clk_i);
            chk("mis_err", 32'(err_o), 1);
            chk("mis_req", 32'(req_o), 0);
            chk("mis_stall", 32'(stall_o), 0);
            chk("mis_nowrite", 32'(RegWrite_o), 0);
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
        end else begin
            for (int i = 0; i <= waits; i++) begin
                ack_i   = (i == waits);
                rdata_i = (i == waits) ? word : $urandom;
                @(negedge clk_i);
                chk("ld_req", 32'(req_o), 1);
                chk("ld_stall", 32'(stall_o), 1);
                chk("ld_addr", addr_o, addr);
                @(posedge clk_i);
                #1;
            end
            ack_i   = 1'b0;
            rdata_i = $urandom;
            expect_write(rd, model_load(word, addr, sz, uns), we);
            if (hold) expect_write(hrd, hdata, 1'b1);
            @(negedge clk_i);
            chk("wb_we", 32'(RegWrite_o), 32'(we && rd != 5'd0));
            chk("wb_stall", 32'(stall_o), 0);
            chk("wb_req", 32'(req_o), 0);
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0; size_i = 2'd0;
        unsigned_i = 1'b0; RDaddr_i = 5'd0; ALUres_i = 32'd0; ack_i = 1'b0; rdata_i = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_we", 32'(RegWrite_o), 0);
        chk("rst_rd", 32'(RDaddr_o), 0);
        chk("rst_data", RDdata_o, 0);
        chk("rst_req", 32'(req_o), 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_retired", retired_o, 0);
        rst_i = 1'b0;
        idle(1);

        // Back-to-back ALU ops; rd 0 must not write.
        alu(5'd3, 32'h11, 1'b1);
        chk("b2b_we1", 32'(RegWrite_o), 1);
        chk("b2b_rd1", 32'(RDaddr_o), 3);
        alu(5'd5, 32'h22, 1'b1);
        chk("b2b_we2", 32'(RegWrite_o), 1);
        chk("b2b_rd2", 32'(RDaddr_o), 5);
        alu(5'd0, 32'h33, 1'b1);
        chk("b2b_we3", 32'(RegWrite_o), 0);
        chk("b2b_hold_rd", 32'(RDaddr_o), 5);
        chk("b2b_hold_data", RDdata_o, 32'h22);
        idle(2);
        chk("b2b_retired", retired_o, 2);

        load(5'd8, 32'h100, 2'd2, 1'b0, 1'b1, 3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("word_data", RDdata_o, 32'hDEADBEEF);
        chk("word_we_pulse", 32'(RegWrite_o), 0);
        load(5'd1, 32'h103, 2'd0, 1'b0, 1'b1, 0, 32'h80FF0000, 1'b0, 5'd0, 32'd0);
        chk("byte_signed", RDdata_o, 32'hFFFFFF80);
        load(5'd2, 32'h103, 2'd0, 1'b1, 1'b1, 1, 32'h80FF0000, 1'b0, 5'd0, 32'd0);
        chk("byte_unsigned", RDdata_o, 32'h00000080);
        load(5'd4, 32'h102, 2'd1, 1'b0, 1'b1, 0, 32'h80FF0000, 1'b0, 5'd0, 32'd0);
        chk("half_signed", RDdata_o, 32'hFFFF80FF);
        load(5'd6, 32'h101, 2'd1, 1'b0, 1'b1, 0, 32'h12345678, 1'b0, 5'd0, 32'd0);
        idle(1);
        chk("mis_data_kept", RDdata_o, 32'hFFFF80FF);

        // ALU op presented during a load is held until the WRITE cycle.
        load(5'd10, 32'h200, 2'd2, 1'b0, 1'b1, 2, 32'h12345678, 1'b1, 5'd9, 32'h55);
        chk("held_we", 32'(RegWrite_o), 1);
        chk("held_rd", 32'(RDaddr_o), 9);
        chk("held_data", RDdata_o, 32'h55);
        idle(2);
        chk("dir_err_count", 32'(err_seen), 32'(err_exp));
        chk("dir_retired", retired_o, 32'(writes_exp));
        chk("dir_drained", 32'(exp_q.size()), 0);

        // Reset while a load is outstanding abandons it.
        valid_i = 1'b1; MemRead_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd7;
        ALUres_i = 32'h300; size_i = 2'd2;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("pre_rst_stall", 32'(stall_o), 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        writes_exp = 0;
        chk("abandon_req", 32'(req_o), 0);
        chk("abandon_stall", 32'(stall_o), 0);
        chk("abandon_retired", retired_o, 0);
        ack_i = 1'b1; rdata_i = 32'hCAFEF00D;
        @(posedge clk_i);
        #1;
        ack_i = 1'b0;
        idle(1);
        chk("abandon_nowrite", 32'(RegWrite_o), 0);
        chk("abandon_req2", 32'(req_o), 0);
        chk("abandon_retired2", retired_o, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  rd;
            logic [31:0] a;
            rd = 5'($urandom_range(0, 31));
            if ($urandom % 2 == 0) begin
                alu(rd, $urandom, ($urandom % 8) != 0);
            end else begin
                a = 32'h1000 + $urandom_range(0, 255);
                load(rd, a, 2'($urandom), 1'($urandom), ($urandom % 8) != 0,
                     $urandom_range(0, 3), $urandom, ($urandom % 3) == 0,
                     5'($urandom_range(0, 31)), $urandom);
            end
            if ($urandom % 5 == 0) idle(1);
        end
        idle(3);
        chk("rand_drained", 32'(exp_q.size()), 0);
        chk("rand_retired", retired_o, 32'(writes_exp));
        chk("rand_err_count", 32'(err_seen), 32'(err_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
